// File: rtl/dct_block_sequencer.sv
// Row-pass sequencer and transpose buffer for an 8x8 DCT block.
// Optional macro DCT_SEQ_PINGPONG_EN selects a double-buffered transpose store.
module dct_block_sequencer #(
    parameter int N_ROWS = 8,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_ROWS*PIX_W-1:0]    in_data,
    input  logic                       cfg_dc_scale,
    output logic [N_ROWS*PIX_W-1:0]    core_data_in,
    output logic                       core_control,
    input  logic [N_ROWS*COEF_W-1:0]   core_data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_ROWS*COEF_W-1:0]   out_data,
    output logic                       out_last,
    output logic                       busy
);

    logic [COEF_W-1:0] row_elems [N_ROWS];
    logic              in_fire;
    logic              out_fire;
    logic [2:0]        row_cnt;
    logic [2:0]        col_cnt;

    assign core_data_in = in_data;
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;
    assign out_last     = out_valid && (col_cnt == 3'd7);

    always_comb begin
        for (int j = 0; j < N_ROWS; j++) begin
            row_elems[j] = core_data_out[(N_ROWS-j)*COEF_W-1 -: COEF_W];
        end
    end

`ifndef DCT_SEQ_PINGPONG_EN

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              dc_scale_q;
    logic [COEF_W-1:0] tbuf [N_ROWS][N_ROWS];

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && row_cnt == 3'd7) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && col_cnt == 3'd7) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Both counters wrap 7->0, which is exactly the value each phase restarts at.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_cnt    <= 3'd0;
            col_cnt    <= 3'd0;
            dc_scale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                row_cnt <= row_cnt + 3'd1;
                if (state_q == IDLE) dc_scale_q <= cfg_dc_scale;
            end
            if (out_fire) col_cnt <= col_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) tbuf[row_cnt] <= row_elems;
    end

    always_comb begin
        out_data = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            out_data[(N_ROWS-r)*COEF_W-1 -: COEF_W] = tbuf[r][col_cnt];
        end
    end

    assign core_control = (state_q == IDLE) ? cfg_dc_scale : dc_scale_q;
    assign busy         = (state_q != IDLE);

`else

    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic [1:0]        dc_scale_q;
    logic [COEF_W-1:0] tbuf [2][N_ROWS][N_ROWS];

    // A bank being filled is never full, so wr_bank==rd_bank never fires both sides.
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full       <= 2'b00;
            dc_scale_q <= 2'b00;
            row_cnt    <= 3'd0;
            col_cnt    <= 3'd0;
        end else begin
            if (in_fire) begin
                row_cnt <= row_cnt + 3'd1;
                if (row_cnt == 3'd0) dc_scale_q[wr_bank] <= cfg_dc_scale;
                if (row_cnt == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (out_fire) begin
                col_cnt <= col_cnt + 3'd1;
                if (col_cnt == 3'd7) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) tbuf[wr_bank][row_cnt] <= row_elems;
    end

    always_comb begin
        out_data = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            out_data[(N_ROWS-r)*COEF_W-1 -: COEF_W] = tbuf[rd_bank][r][col_cnt];
        end
    end

    assign core_control = (row_cnt == 3'd0) ? cfg_dc_scale : dc_scale_q[wr_bank];
    assign busy         = (|full) || (row_cnt != 3'd0);

`endif

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed bench for dct_block_sequencer; a stub core tags each coefficient
// with its pixel and the control bit so transposition and control can be seen.
module tb_dct_block_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        cfg_dc_scale;
    logic [63:0] core_data_in;
    logic        core_control;
    logic [95:0] core_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dct_block_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .cfg_dc_scale (cfg_dc_scale),
        .core_data_in (core_data_in),
        .core_control (core_control),
        .core_data_out(core_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy)
    );

    // Stub core: z_j = {control, 3'b0, x_j}
    always_comb begin
        core_data_out = '0;
        for (int j = 0; j < 8; j++) begin
            core_data_out[95-12*j -: 12] = {core_control, 3'b000, core_data_in[63-8*j -: 8]};
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input logic [7:0] base, input logic [7:0] stp,
                                       input int r, input int j);
        return base + stp * 8'(16 * r + j);
    endfunction

    function automatic logic [63:0] row_word(input logic [7:0] base, input logic [7:0] stp,
                                             input int r);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[63-8*j -: 8] = pix(base, stp, r, j);
        return w;
    endfunction

    function automatic logic [95:0] col_word(input logic [7:0] base, input logic [7:0] stp,
                                             input logic ctrl, input int c);
        logic [95:0] w;
        for (int r = 0; r < 8; r++) w[95-12*r -: 12] = {ctrl, 3'b000, pix(base, stp, r, c)};
        return w;
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input logic [7:0] base, input logic [7:0] stp, input logic cfg0,
                             input logic toggle, input int n, input int gap_row);
        for (int r = 0; r < n; r++) begin
            if (r == gap_row) begin
                in_valid = 1'b0;
                repeat (2) begin
                    step_clk();
                    chk("gap_in_ready", 96'(in_ready), 96'(1));
                    chk("gap_busy", 96'(busy), 96'(1));
                    chk("gap_out_valid", 96'(out_valid), 96'(0));
                end
            end
            in_valid     = 1'b1;
            in_data      = row_word(base, stp, r);
            cfg_dc_scale = toggle ? (cfg0 ^ 1'(r & 1)) : cfg0;
            #1;
            chk("load_in_ready", 96'(in_ready), 96'(1));
            chk("core_data_in", 96'(core_data_in), 96'(row_word(base, stp, r)));
            chk("core_control", 96'(core_control), 96'(cfg0));
            chk("load_out_valid", 96'(out_valid), 96'(0));
            step_clk();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic [7:0] base, input logic [7:0] stp, input logic ctrl,
                         input int stall_col);
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b1;
            #1;
            chk("drain_out_valid", 96'(out_valid), 96'(1));
            chk("drain_out_data", out_data, col_word(base, stp, ctrl, c));
            chk("drain_out_last", 96'(out_last), 96'(c == 7));
            chk("drain_in_ready", 96'(in_ready), 96'(0));
            if (c == stall_col) begin
                out_ready = 1'b0;
                repeat (5) begin
                    step_clk();
                    chk("stall_out_data", out_data, col_word(base, stp, ctrl, c));
                    chk("stall_out_valid", 96'(out_valid), 96'(1));
                    chk("stall_out_last", 96'(out_last), 96'(0));
                    chk("stall_in_ready", 96'(in_ready), 96'(0));
                end
                out_ready = 1'b1;
            end
            step_clk();
        end
        out_ready = 1'b0;
        #1;
        chk("post_busy", 96'(busy), 96'(0));
        chk("post_out_valid", 96'(out_valid), 96'(0));
        chk("post_out_last", 96'(out_last), 96'(0));
        chk("post_in_ready", 96'(in_ready), 96'(1));
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        cfg_dc_scale = 1'b0;
        out_ready    = 1'b0;
        repeat (2) step_clk();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_out_last", 96'(out_last), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));

`ifdef DCT_SEQ_PINGPONG_EN
        out_ready = 1'b1;
        for (int t = 0; t < 32; t++) begin
            in_valid     = (t < 24);
            in_data      = row_word(8'((t / 8) * 7), 8'd1, t % 8);
            cfg_dc_scale = 1'b0;
            #1;
            if (t < 24) chk("pp_in_ready", 96'(in_ready), 96'(1));
            if (t >= 8) begin
                chk("pp_out_valid", 96'(out_valid), 96'(1));
                chk("pp_out_data", out_data,
                    col_word(8'(((t - 8) / 8) * 7), 8'd1, 1'b0, (t - 8) % 8));
                chk("pp_out_last", 96'(out_last), 96'(((t - 8) % 8) == 7));
            end
            step_clk();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pp_busy", 96'(busy), 96'(0));
        chk("pp_out_valid_end", 96'(out_valid), 96'(0));
`else
        send_rows(8'h00, 8'h00, 1'b0, 1'b0, 8, -1);
        drain(8'h00, 8'h00, 1'b0, -1);

        send_rows(8'h01, 8'h00, 1'b0, 1'b0, 8, -1);
        drain(8'h01, 8'h00, 1'b0, -1);

        send_rows(8'h05, 8'h01, 1'b1, 1'b1, 8, -1);
        drain(8'h05, 8'h01, 1'b1, -1);

        send_rows(8'h20, 8'h03, 1'b0, 1'b0, 8, 3);
        drain(8'h20, 8'h03, 1'b0, 3);

        send_rows(8'hA0, 8'h01, 1'b0, 1'b0, 4, -1);
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        #1;
        chk("midrst_busy", 96'(busy), 96'(0));
        chk("midrst_in_ready", 96'(in_ready), 96'(1));
        chk("midrst_out_valid", 96'(out_valid), 96'(0));
        send_rows(8'h40, 8'h01, 1'b1, 1'b0, 8, -1);
        drain(8'h40, 8'h01, 1'b1, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dct_block_sequencer.md
Name: dct_block_sequencer

Overview:
- Sequences one 8x8 pixel block through the combinational 8-point 1-D DCT core (DCT_2D), one row per accepted beat.
- Captures each 96-bit row-coefficient result in a transpose buffer, then streams the block out column by column for the column pass.
- Sits between the pixel source and the column-pass stage.
- Valid/ready on both sides; the core's `control` input is set per block.

Parameters:
- N_ROWS, 8, rows per block, also the columns emitted per block (fixed at 8; counters are 3 bits).
- PIX_W, 8, input sample width (core input is 8*PIX_W).
- COEF_W, 12, coefficient width (core output is 8*COEF_W).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  pixel row valid.
- in_ready  out  1  sequencer accepts a row this cycle.
- in_data  in  64  row of 8 pixels; x0 in [63:56], x7 in [7:0].
- cfg_dc_scale  in  1  DC scaling select; sampled on the first row of a block.
- core_data_in  out  64  to core data_in; equals in_data combinationally.
- core_control  out  1  to core control.
- core_data_out  in  96  from core data_out; z0 in [95:84], z7 in [11:0].
- out_valid  out  1  column valid.
- out_ready  in  1  downstream accepts column.
- out_data  out  96  column j = {buf[0][j], buf[1][j], ..., buf[7][j]}; row 0 in [95:84].
- out_last  out  1  high with column 7.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, row_cnt=0, col_cnt=0, dc_scale_q=0.
  - in_ready=1, out_valid=0, out_last=0, busy=0.
  - Buffer contents are don't-care.
- States:
  - IDLE: in_ready=1. An accepted row stores to buf[0], samples cfg_dc_scale into dc_scale_q, row_cnt becomes 1, next state LOAD.
  - LOAD: in_ready=1. Each accepted row stores to buf[row_cnt] and increments row_cnt. Acceptance with row_cnt=7 sets next state DRAIN and col_cnt=0.
  - DRAIN: out_valid=1, out_data = column col_cnt. Each out_valid&&out_ready increments col_cnt. The handshake at col_cnt=7 returns to IDLE with row_cnt=0.
- core_control is cfg_dc_scale while in IDLE, otherwise dc_scale_q, so all 8 rows of a block see the same value.
- Capture: on in_valid&&in_ready, core_data_out is written into buffer row row_cnt on the same clk edge. Zero-cycle core latency.
- Latency: first column is valid on the cycle after the 8th row is accepted. Minimum block period without PINGPONG_EN is 16 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- No input accepted in DRAIN (in_ready=0) unless PINGPONG_EN.
- in_valid=0 mid-LOAD: stall, row_cnt holds; no timeout.
- Reset mid-operation discards the partial block. The first row after reset is row 0.
- Buffer: 8 rows x 8 elements x COEF_W flops. Element j of a row is core_data_out[95-12j -: 12].
- No arithmetic in the sequencer; no saturation or rounding.

Optional Feature:
- Macro: DCT_SEQ_PINGPONG_EN.
- Defined:
  - Two transpose buffers; load and drain proceed concurrently on opposite banks.
  - in_ready=1 in DRAIN unless the other bank is full and not yet drained. in_ready=0 only when both banks are full.
  - A bank switches to drain when its 8th row is accepted. If the other bank is still draining, it queues and drains immediately after column 7 of that bank.
  - Each bank holds its own dc_scale_q.
  - Sustained throughput: one row in and one column out per cycle; 8-cycle block period.
- Undefined: single buffer, behaviour as above.

Test Plan:
- Reset, then 8 rows of 0x00 with cfg_dc_scale=0 -> 8 columns, all out_data=0, out_last only on the 8th, busy falls the cycle after.
- 8 rows of 0x0101010101010101, cfg_dc_scale=0 -> column 0 = 8x 0x05B, columns 1-7 = 0, core_control=0 throughout.
- Same rows, cfg_dc_scale=1 on the first row and toggled afterward -> core_control=1 for all 8 rows, column 0 = 8x 0x016.
- out_ready held 0 for 5 cycles on column 3 -> out_data stable, col_cnt holds, in_ready=0 (non-pingpong).
- rst_n=0 after 4 rows, then 8 fresh rows -> the block contains only the fresh rows; no output before 8 rows.
- DCT_SEQ_PINGPONG_EN: 3 back-to-back blocks with in_valid and out_ready always high -> in_ready never drops, 24 columns out in order with no gaps after the first.
